// File: rtl/dc_pred_gen.sv
// DC intra predictor: latches top/left neighbours, sums LANES samples per side per cycle,
// rounds by availability. Optional `dst` fill bank built only when DC_PRED_FILL_EN is defined.

module dc_lane #(
  parameter int BW = 8
) (
  input  logic          ta,
  input  logic          la,
  input  logic [BW-1:0] ts,
  input  logic [BW-1:0] ls,
  output logic [BW:0]   s
);
  assign s = (ta ? {1'b0, ts} : '0) + (la ? {1'b0, ls} : '0);
endmodule

module dc_pred_gen #(
  parameter int BIT_WIDTH  = 8,
  parameter int BLOCK_SIZE = 16,
  parameter int LANES      = 4
) (
  input  logic                                    clk,
  input  logic                                    rst_n,
  input  logic                                    start,
  input  logic                                    top_avail,
  input  logic                                    left_avail,
  input  logic [BIT_WIDTH*BLOCK_SIZE-1:0]         top,
  input  logic [BIT_WIDTH*BLOCK_SIZE-1:0]         left,
  output logic                                    busy,
  output logic                                    done,
  output logic [BIT_WIDTH-1:0]                    dc_val,
  output logic [BIT_WIDTH*BLOCK_SIZE*BLOCK_SIZE-1:0] dst
);
  localparam int LOG2_BS = $clog2(BLOCK_SIZE);
  localparam int N_ACC   = BLOCK_SIZE / LANES;
  localparam int SUM_W   = BIT_WIDTH + LOG2_BS + 1;
  localparam int CNT_W   = (N_ACC > 1) ? $clog2(N_ACC) : 1;

  typedef enum logic [1:0] {IDLE, ACC, NORM, DONE} state_t;

  state_t                               state;
  logic [BLOCK_SIZE-1:0][BIT_WIDTH-1:0] top_r, left_r;
  logic                                 ta_r, la_r;
  logic [SUM_W-1:0]                     sum, step;
  logic [CNT_W-1:0]                     cnt;
  logic [LANES-1:0][BIT_WIDTH:0]        lane_s;
  logic [BIT_WIDTH-1:0]                 dc_next;

  // Latched rows shift down by LANES samples each ACC cycle, so lanes always read slot 0..LANES-1.
  for (genvar l = 0; l < LANES; l++) begin : g_lane
    dc_lane #(.BW(BIT_WIDTH)) u_lane (
      .ta(ta_r), .la(la_r), .ts(top_r[l]), .ls(left_r[l]), .s(lane_s[l])
    );
  end

  always_comb begin
    step = '0;
    for (int i = 0; i < LANES; i++) step = step + SUM_W'(lane_s[i]);
  end

  always_comb begin
    if (ta_r && la_r)
      dc_next = BIT_WIDTH'((sum + SUM_W'(BLOCK_SIZE)) >> (LOG2_BS + 1));
    else if (ta_r || la_r)
      dc_next = BIT_WIDTH'((sum + SUM_W'(BLOCK_SIZE / 2)) >> LOG2_BS);
    else
      dc_next = BIT_WIDTH'(1) << (BIT_WIDTH - 1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      dc_val <= '0;
      sum    <= '0;
      cnt    <= '0;
      top_r  <= '0;
      left_r <= '0;
      ta_r   <= 1'b0;
      la_r   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            top_r  <= top;
            left_r <= left;
            ta_r   <= top_avail;
            la_r   <= left_avail;
            sum    <= '0;
            cnt    <= '0;
            busy   <= 1'b1;
            state  <= (top_avail || left_avail) ? ACC : NORM;
          end
        end
        ACC: begin
          sum    <= sum + step;
          top_r  <= top_r >> (LANES * BIT_WIDTH);
          left_r <= left_r >> (LANES * BIT_WIDTH);
          cnt    <= cnt + CNT_W'(1);
          if (cnt == CNT_W'(N_ACC - 1)) state <= NORM;
        end
        NORM: begin
          dc_val <= dc_next;
          done   <= 1'b1;
          state  <= DONE;
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef DC_PRED_FILL_EN
  logic [BIT_WIDTH*BLOCK_SIZE*BLOCK_SIZE-1:0] dst_r;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)             dst_r <= '0;
    else if (state == NORM) dst_r <= {(BLOCK_SIZE*BLOCK_SIZE){dc_next}};
  end
  assign dst = dst_r;
`else
  assign dst = '0;
`endif

endmodule

// File: tb/tb_dc_pred_gen.sv
// Self-checking bench for dc_pred_gen: directed, random and robustness scenarios against
// an arithmetic reference model, on a default instance and an 8x8 / 8-lane instance.

module tb_dc_pred_gen;
  localparam int W    = 8 * 16;
  localparam int DW   = 8 * 256;
  localparam int W8   = 8 * 8;
  localparam int DW8  = 8 * 64;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           start, top_avail, left_avail;
  logic [W-1:0]   top, left;
  logic           busy, done;
  logic [7:0]     dc_val;
  logic [DW-1:0]  dst;

  logic           start8, ta8, la8;
  logic [W8-1:0]  top8, left8;
  logic           busy8, done8;
  logic [7:0]     dc_val8;
  logic [DW8-1:0] dst8;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dc_pred_gen u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .top_avail(top_avail), .left_avail(left_avail),
    .top(top), .left(left), .busy(busy), .done(done), .dc_val(dc_val), .dst(dst)
  );

  dc_pred_gen #(.BIT_WIDTH(8), .BLOCK_SIZE(8), .LANES(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .top_avail(ta8), .left_avail(la8),
    .top(top8), .left(left8), .busy(busy8), .done(done8), .dc_val(dc_val8), .dst(dst8)
  );

  // Reference: average of available neighbours with round-half-up via integer division.
  function automatic int ref_dc(input logic [W-1:0] tv, input logic [W-1:0] lv,
                                input bit ta, input bit la, input int bs);
    int s = 0;
    for (int i = 0; i < bs; i++) begin
      if (ta) s += int'(tv[i*8 +: 8]);
      if (la) s += int'(lv[i*8 +: 8]);
    end
    if (ta && la)     return (s + bs) / (2 * bs);
    else if (ta || la) return (s + bs / 2) / bs;
    else              return 128;
  endfunction

  function automatic logic [DW-1:0] exp_dst(input logic [7:0] v);
`ifdef DC_PRED_FILL_EN
    return {256{v}};
`else
    return '0;
`endif
  endfunction

  function automatic logic [DW8-1:0] exp_dst8(input logic [7:0] v);
`ifdef DC_PRED_FILL_EN
    return {64{v}};
`else
    return '0;
`endif
  endfunction

  function automatic logic [W-1:0] rand_row();
    logic [W-1:0] r;
    for (int i = 0; i < 4; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // Issues one request and follows it until busy drops; lat = -1 if done never appears.
  task automatic do_req(input bit ta, input bit la, input logic [W-1:0] tv,
                        input logic [W-1:0] lv, output int lat, output int bcnt);
    @(negedge clk);
    start = 1'b1; top_avail = ta; left_avail = la; top = tv; left = lv;
    @(posedge clk); #1;
    start = 1'b0;
    lat  = -1;
    bcnt = busy ? 1 : 0;
    for (int n = 1; n <= 30; n++) begin
      @(posedge clk); #1;
      if (busy) bcnt++;
      if (done && lat < 0) lat = n;
      if (!busy && lat >= 0) break;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 0; top_avail = 0; left_avail = 0; top = '0; left = '0;
    start8 = 0; ta8 = 0; la8 = 0; top8 = '0; left8 = '0;
    #23;
    checks += 4;
    if (busy !== 1'b0)   begin errors++; $display("FAIL reset_busy: got %b exp 0", busy); end
    if (done !== 1'b0)   begin errors++; $display("FAIL reset_done: got %b exp 0", done); end
    if (dc_val !== 8'h0) begin errors++; $display("FAIL reset_dc: got %0h exp 0", dc_val); end
    if (dst !== '0)      begin errors++; $display("FAIL reset_dst: nonzero"); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_directed();
    logic [W-1:0] tv, lv;
    bit ta, la;
    int lat, bcnt, exp_v, exp_lat;
    for (int c = 0; c < 5; c++) begin
      case (c)
        0: begin tv = {16{8'h10}}; lv = {16{8'h20}}; ta = 1; la = 1; exp_v = 8'h18; end
        1: begin tv = {16{8'hFF}}; lv = rand_row(); ta = 1; la = 0; exp_v = 8'hFF; end
        2: begin
             tv = rand_row(); ta = 0; la = 1; exp_v = 8;
             for (int i = 0; i < 16; i++) lv[i*8 +: 8] = 8'(i);
           end
        3: begin tv = rand_row(); lv = rand_row(); ta = 0; la = 0; exp_v = 8'h80; end
        default: begin tv = {16{8'h01}}; lv = '0; ta = 1; la = 1; exp_v = 1; end
      endcase
      exp_lat = (ta || la) ? 5 : 1;
      do_req(ta, la, tv, lv, lat, bcnt);
      checks += 4;
      if (lat !== exp_lat)
        begin errors++; $display("FAIL dir%0d_latency: got %0d exp %0d", c, lat, exp_lat); end
      if (bcnt !== exp_lat + 1)
        begin errors++; $display("FAIL dir%0d_busy: got %0d exp %0d", c, bcnt, exp_lat + 1); end
      if (dc_val !== 8'(exp_v))
        begin errors++; $display("FAIL dir%0d_dc: got %0h exp %0h", c, dc_val, exp_v); end
      if (dst !== exp_dst(8'(exp_v)))
        begin errors++; $display("FAIL dir%0d_dst: got %0h exp %0h", c, dst[7:0], exp_v); end
    end
  endtask

  task automatic test_random();
    logic [W-1:0] tv, lv;
    bit ta, la;
    int lat, bcnt, exp_v;
    for (int c = 0; c < 24; c++) begin
      tv = rand_row(); lv = rand_row();
      ta = 1'($urandom); la = 1'($urandom);
      exp_v = ref_dc(tv, lv, ta, la, 16);
      do_req(ta, la, tv, lv, lat, bcnt);
      checks += 3;
      if (lat !== ((ta || la) ? 5 : 1))
        begin errors++; $display("FAIL rnd%0d_latency: got %0d", c, lat); end
      if (dc_val !== 8'(exp_v))
        begin errors++; $display("FAIL rnd%0d_dc: got %0h exp %0h", c, dc_val, exp_v); end
      if (dst !== exp_dst(8'(exp_v)))
        begin errors++; $display("FAIL rnd%0d_dst: got %0h exp %0h", c, dst[7:0], exp_v); end
    end
  endtask

  task automatic test_input_change();
    logic [W-1:0] tv, lv;
    int exp_v, lat;
    tv = rand_row(); lv = rand_row();
    exp_v = ref_dc(tv, lv, 1, 1, 16);
    @(negedge clk);
    start = 1; top_avail = 1; left_avail = 1; top = tv; left = lv;
    @(posedge clk); #1;
    start = 0;
    lat = -1;
    for (int n = 1; n <= 30 && lat < 0; n++) begin
      @(negedge clk);
      top = rand_row(); left = rand_row();
      top_avail = 1'($urandom); left_avail = 1'($urandom);
      @(posedge clk); #1;
      if (done) lat = n;
    end
    checks += 2;
    if (lat !== 5)        begin errors++; $display("FAIL chg_latency: got %0d exp 5", lat); end
    if (dc_val !== 8'(exp_v))
      begin errors++; $display("FAIL chg_dc: got %0h exp %0h", dc_val, exp_v); end
    repeat (2) @(posedge clk);
  endtask

  task automatic test_start_ignored();
    logic [W-1:0] tv, lv;
    int exp_v, lat, ndone;
    tv = rand_row(); lv = rand_row();
    exp_v = ref_dc(tv, lv, 1, 0, 16);
    @(negedge clk);
    start = 1; top_avail = 1; left_avail = 0; top = tv; left = lv;
    @(posedge clk); #1;
    start = 0;
    @(negedge clk);
    @(negedge clk);
    start = 1; top_avail = 1; left_avail = 1; top = {16{8'h00}}; left = {16{8'hFF}};
    @(negedge clk);
    start = 0;
    lat = -1; ndone = 0;
    for (int n = 0; n < 20; n++) begin
      @(posedge clk); #1;
      if (done) begin ndone++; if (lat < 0) lat = n; end
    end
    checks += 2;
    if (dc_val !== 8'(exp_v))
      begin errors++; $display("FAIL ign_dc: got %0h exp %0h", dc_val, exp_v); end
    if (ndone !== 1) begin errors++; $display("FAIL ign_done_count: got %0d exp 1", ndone); end
  endtask

  task automatic test_reset_mid();
    int ndone;
    @(negedge clk);
    start = 1; top_avail = 1; left_avail = 1; top = rand_row(); left = rand_row();
    @(posedge clk); #1;
    start = 0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 0;
    #1;
    checks += 1;
    if (busy !== 0 || done !== 0 || dc_val !== 8'h0 || dst !== '0)
      begin errors++; $display("FAIL rstmid_outputs: busy %b done %b dc %0h exp all 0", busy, done, dc_val); end
    @(negedge clk);
    rst_n = 1;
    ndone = 0;
    for (int n = 0; n < 10; n++) begin
      @(posedge clk); #1;
      if (done || busy) ndone++;
    end
    checks += 1;
    if (ndone !== 0) begin errors++; $display("FAIL rstmid_no_done: got %0d active cycles exp 0", ndone); end
  endtask

  task automatic test_small();
    logic [W-1:0] tv, lv;
    int exp_v, lat;
    for (int c = 0; c < 4; c++) begin
      tv = rand_row(); lv = rand_row();
      if (c == 0) begin tv[W8-1:0] = {8{8'hFF}}; lv[W8-1:0] = {8{8'hFF}}; end
      exp_v = ref_dc(tv, lv, 1, 1, 8);
      @(negedge clk);
      start8 = 1; ta8 = 1; la8 = 1; top8 = tv[W8-1:0]; left8 = lv[W8-1:0];
      @(posedge clk); #1;
      start8 = 0;
      lat = -1;
      for (int n = 1; n <= 20 && lat < 0; n++) begin
        @(posedge clk); #1;
        if (done8) lat = n;
      end
      checks += 3;
      if (lat !== 2) begin errors++; $display("FAIL small%0d_latency: got %0d exp 2", c, lat); end
      if (dc_val8 !== 8'(exp_v))
        begin errors++; $display("FAIL small%0d_dc: got %0h exp %0h", c, dc_val8, exp_v); end
      if (dst8 !== exp_dst8(8'(exp_v)))
        begin errors++; $display("FAIL small%0d_dst: got %0h exp %0h", c, dst8[7:0], exp_v); end
      repeat (2) @(posedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_input_change();
    test_start_ignored();
    test_reset_mid();
    test_small();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
